// File: rtl/ysyx_23060124_wbu_pkg.sv
// ============================================================================
// ysyx_23060124_wbu_pkg : control-class encodings and buffer states for the WBU
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_23060124_wbu_pkg;

  localparam logic [2:0] WB_KIND_SEQ   = 3'd0;
  localparam logic [2:0] WB_KIND_BRCH  = 3'd1;
  localparam logic [2:0] WB_KIND_JAL   = 3'd2;
  localparam logic [2:0] WB_KIND_JALR  = 3'd3;
  localparam logic [2:0] WB_KIND_ECALL = 3'd4;
  localparam logic [2:0] WB_KIND_MRET  = 3'd5;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wbu_state_t;

  // Branches and privileged control transfers never touch the register file.
  function automatic logic kind_writes_rf(input logic [2:0] kind);
    return !((kind == WB_KIND_BRCH) || (kind == WB_KIND_ECALL) ||
             (kind == WB_KIND_MRET));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060124_npc_gen.sv
// ============================================================================
// ysyx_23060124_npc_gen : combinational next-PC selection, shared with fetch
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_23060124_npc_gen
  import ysyx_23060124_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_kind,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_src1,
  input  logic            i_taken,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic [XLEN-1:0] o_npc
);

  localparam logic [XLEN-1:0] C_FOUR      = XLEN'(4);
  localparam logic [XLEN-1:0] C_LSB_CLEAR = ~XLEN'(1);

  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_jalr;

  assign w_pc_imm = i_pc + i_imm;
  assign w_pc_seq = i_pc + C_FOUR;
  assign w_jalr   = (i_src1 + i_imm) & C_LSB_CLEAR;

  // Undefined encodings fall through to sequential flow.
  always_comb begin
    o_npc = w_pc_seq;
    case (i_kind)
      WB_KIND_ECALL: o_npc = i_mtvec;
      WB_KIND_MRET:  o_npc = i_mepc;
      WB_KIND_JALR:  o_npc = w_jalr;
      WB_KIND_JAL:   o_npc = w_pc_imm;
      WB_KIND_BRCH:  o_npc = i_taken ? w_pc_imm : w_pc_seq;
      default:       o_npc = w_pc_seq;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060124_wbu.sv
// ============================================================================
// ysyx_23060124_wbu : single-entry write-back stage (commit, next PC, ecall)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_23060124_wbu
  import ysyx_23060124_wbu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_pre_valid,
  output logic            o_pre_ready,
  input  logic [XLEN-1:0] i_res,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_src1,
  input  logic [RA_W-1:0] i_rd,
  input  logic            i_rd_wen,
  input  logic [2:0]      i_kind,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_post_valid,
  input  logic            i_post_ready,
  output logic [XLEN-1:0] o_npc,
  output logic            o_rf_wen,
  output logic [RA_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_ecall,
  output logic [XLEN-1:0] o_epc
);

  wbu_state_t      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_res;
  logic [RA_W-1:0] r_rd;
  logic            r_rd_wen;
  logic [2:0]      r_kind;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;

  logic            w_full;
  logic            w_pre_fire;
  logic            w_post_fire;
  logic [XLEN-1:0] w_npc;

  assign w_full       = (r_state == ST_FULL);
  assign o_pre_ready  = (!w_full || i_post_ready) && !i_rst;
  assign o_post_valid = w_full;
  assign w_pre_fire   = i_pre_valid && o_pre_ready;
  // A commit that coincides with reset is dropped, so no side effects escape.
  assign w_post_fire  = w_full && i_post_ready && !i_rst;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state  <= ST_EMPTY;
      r_pc     <= '0;
      r_imm    <= '0;
      r_src1   <= '0;
      r_res    <= '0;
      r_rd     <= '0;
      r_rd_wen <= 1'b0;
      r_kind   <= WB_KIND_SEQ;
      r_mtvec  <= '0;
      r_mepc   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_pre_fire) r_state <= ST_FULL;
        ST_FULL:  if (w_post_fire && !w_pre_fire) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
      if (w_pre_fire) begin
        r_pc     <= i_pc;
        r_imm    <= i_imm;
        r_src1   <= i_src1;
        r_res    <= i_res;
        r_rd     <= i_rd;
        r_rd_wen <= i_rd_wen;
        r_kind   <= i_kind;
        r_mtvec  <= i_mtvec;
        r_mepc   <= i_mepc;
      end
    end
  end

  ysyx_23060124_npc_gen #(
    .XLEN (XLEN)
  ) u_npc_gen (
    .i_kind  (r_kind),
    .i_pc    (r_pc),
    .i_imm   (r_imm),
    .i_src1  (r_src1),
    .i_taken (r_res[0]),
    .i_mtvec (r_mtvec),
    .i_mepc  (r_mepc),
    .o_npc   (w_npc)
  );

  assign o_npc      = w_full ? w_npc : '0;
  assign o_rf_wen   = w_post_fire && r_rd_wen && (r_rd != '0) && kind_writes_rf(r_kind);
  assign o_rf_waddr = r_rd;
  assign o_rf_wdata = r_res;
  assign o_ecall    = w_post_fire && (r_kind == WB_KIND_ECALL);
  assign o_epc      = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060124_wbu.sv
// ============================================================================
// tb_ysyx_23060124_wbu : scoreboard bench for the write-back stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060124_wbu;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk;
  logic            i_rst;
  logic            i_pre_valid;
  logic            o_pre_ready;
  logic [XLEN-1:0] i_res, i_pc, i_imm, i_src1, i_mtvec, i_mepc;
  logic [RA_W-1:0] i_rd;
  logic            i_rd_wen;
  logic [2:0]      i_kind;
  logic            o_post_valid;
  logic            i_post_ready;
  logic [XLEN-1:0] o_npc, o_rf_wdata, o_epc;
  logic            o_rf_wen, o_ecall;
  logic [RA_W-1:0] o_rf_waddr;

  ysyx_23060124_wbu #(.XLEN(XLEN), .RA_W(RA_W)) u_dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .i_res        (i_res),
    .i_pc         (i_pc),
    .i_imm        (i_imm),
    .i_src1       (i_src1),
    .i_rd         (i_rd),
    .i_rd_wen     (i_rd_wen),
    .i_kind       (i_kind),
    .i_mtvec      (i_mtvec),
    .i_mepc       (i_mepc),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready),
    .o_npc        (o_npc),
    .o_rf_wen     (o_rf_wen),
    .o_rf_waddr   (o_rf_waddr),
    .o_rf_wdata   (o_rf_wdata),
    .o_ecall      (o_ecall),
    .o_epc        (o_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc;
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        ecall;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] kind, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [31:0] src1,
                                 input logic [31:0] res, input logic [4:0] rd,
                                 input logic wen, input logic [31:0] mtvec,
                                 input logic [31:0] mepc);
    exp_t e;
    case (kind)
      3'd4:    e.npc = mtvec;
      3'd5:    e.npc = mepc;
      3'd3:    e.npc = {src1[31:1] + imm[31:1] + 31'((src1[0] & imm[0])), 1'b0};
      3'd2:    e.npc = pc + imm;
      3'd1:    e.npc = res[0] ? pc + imm : pc + 32'd4;
      default: e.npc = pc + 32'd4;
    endcase
    e.wen   = wen && (rd != 5'd0) && (kind != 3'd1) && (kind != 3'd4) && (kind != 3'd5);
    e.waddr = {27'd0, rd};
    e.wdata = res;
    e.ecall = (kind == 3'd4);
    e.epc   = pc;
    return e;
  endfunction

  task automatic send(input logic [2:0] kind, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] src1,
                      input logic [31:0] res, input logic [4:0] rd,
                      input logic wen, input logic [31:0] mtvec,
                      input logic [31:0] mepc);
    bit ok = 0;
    i_kind = kind; i_pc = pc; i_imm = imm; i_src1 = src1; i_res = res;
    i_rd = rd; i_rd_wen = wen; i_mtvec = mtvec; i_mepc = mepc;
    i_pre_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (o_pre_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(model(kind, pc, imm, src1, res, rd, wen, mtvec, mepc));
    end
    @(posedge clk); #1;
    i_pre_valid = 1'b0;
  endtask

  // Commit-side monitor: every drained entry is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (i_rst) begin
      check("rst_rf_wen", {31'd0, o_rf_wen}, 32'd0);
      check("rst_ecall", {31'd0, o_ecall}, 32'd0);
      exp_q.delete();
    end else if (o_post_valid && i_post_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("npc", o_npc, e.npc);
        check("rf_wen", {31'd0, o_rf_wen}, {31'd0, e.wen});
        if (e.wen) begin
          check("rf_waddr", {27'd0, o_rf_waddr}, e.waddr);
          check("rf_wdata", o_rf_wdata, e.wdata);
        end
        check("ecall", {31'd0, o_ecall}, {31'd0, e.ecall});
        if (e.ecall) check("epc", o_epc, e.epc);
      end
    end else begin
      check("idle_rf_wen", {31'd0, o_rf_wen}, 32'd0);
      check("idle_ecall", {31'd0, o_ecall}, 32'd0);
    end
  end

  logic [31:0] held_npc;

  initial begin
    i_rst = 1'b1; i_pre_valid = 1'b0; i_post_ready = 1'b1;
    i_kind = 3'd0; i_pc = '0; i_imm = '0; i_src1 = '0; i_res = '0;
    i_rd = '0; i_rd_wen = 1'b0; i_mtvec = '0; i_mepc = '0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("reset_post_valid", {31'd0, o_post_valid}, 32'd0);
    check("reset_npc", o_npc, 32'd0);
    check("reset_waddr", {27'd0, o_rf_waddr}, 32'd0);
    check("reset_wdata", o_rf_wdata, 32'd0);
    check("reset_epc", o_epc, 32'd0);
    check("reset_pre_ready", {31'd0, o_pre_ready}, 32'd1);
    @(posedge clk); #1;

    send(3'd0, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 32'h0, 32'h0);
    send(3'd1, 32'h8000_0010, 32'hFFFF_FFF8, 32'h0, 32'h1, 5'd3, 1'b1, 32'h0, 32'h0);
    send(3'd1, 32'h8000_0010, 32'hFFFF_FFF8, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0, 32'h0);
    send(3'd3, 32'h8000_0020, 32'h4, 32'h8000_0101, 32'h8000_0024, 5'd1, 1'b1, 32'h0, 32'h0);
    repeat (2) @(posedge clk); #1;

    // Stall with the buffer full, then release: drain and refill on one edge.
    i_post_ready = 1'b0;
    send(3'd2, 32'h8000_0100, 32'h20, 32'h0, 32'h8000_0104, 5'd1, 1'b1, 32'h0, 32'h0);
    held_npc = 32'h8000_0120;
    fork
      send(3'd0, 32'h8000_0120, 32'h0, 32'h0, 32'hCAFE_0001, 5'd9, 1'b1, 32'h0, 32'h0);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_pre_ready", {31'd0, o_pre_ready}, 32'd0);
          check("stall_post_valid", {31'd0, o_post_valid}, 32'd1);
          check("stall_npc", o_npc, held_npc);
          check("stall_wdata", o_rf_wdata, 32'h8000_0104);
        end
        @(posedge clk); #1;
        i_post_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk); #1;

    send(3'd4, 32'h8000_0040, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 32'h8000_1000, 32'h0);
    send(3'd5, 32'h8000_0044, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 32'h8000_0044);
    send(3'd0, 32'h8000_0050, 32'h0, 32'h0, 32'h5555_AAAA, 5'd0, 1'b1, 32'h0, 32'h0);
    send(3'd7, 32'h8000_0200, 32'h40, 32'h0, 32'h0000_0777, 5'd31, 1'b1, 32'h0, 32'h0);
    send(3'd2, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'hFFFF_FFF4, 5'd4, 1'b1, 32'h0, 32'h0);
    send(3'd0, 32'h8000_0300, 32'h0, 32'h0, 32'h0000_0042, 5'd6, 1'b0, 32'h0, 32'h0);

    // Bounded drain of the scoreboard before the reset scenario.
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    check("drain_queue_empty", exp_q.size(), 32'd0);
    #1;

    // Reset while full: the entry must vanish without committing.
    i_post_ready = 1'b0;
    send(3'd4, 32'h8000_0400, 32'h0, 32'h0, 32'h0000_0099, 5'd7, 1'b1, 32'h8000_2000, 32'h0);
    @(negedge clk);
    check("pre_rst_full", {31'd0, o_post_valid}, 32'd1);
    @(posedge clk); #1;
    i_rst = 1'b1; i_post_ready = 1'b1;
    @(negedge clk);
    check("rst_pre_ready", {31'd0, o_pre_ready}, 32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'd0, o_post_valid}, 32'd0);
    check("post_rst_npc", o_npc, 32'd0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
